// File: rtl/chip8_draw_ctrl.sv
// chip8_draw_ctrl: CHIP-8 DXYN sprite draw sequencer.
// Fetches N sprite bytes starting at I and XOR-merges each byte into one
// framebuffer row by read-modify-write, accumulating the collision flag.
// Optional feature macro: CHIP8_DRAW_WRAP_EN
//   undefined (default) : pixels past the right edge and rows past the bottom are clipped
//   defined             : columns rotate to column 0 and rows wrap modulo NROWS
module chip8_draw_ctrl #(
  parameter int unsigned MEM_AW = 12,
  parameter int unsigned ROW_W  = 64,
  parameter int unsigned NROWS  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [7:0]                 x_in,
  input  logic [7:0]                 y_in,
  input  logic [3:0]                 n_in,
  input  logic [MEM_AW-1:0]          i_in,
  output logic                       busy,
  output logic                       done,
  output logic                       collision,
  output logic [MEM_AW-1:0]          mem_addr,
  input  logic [7:0]                 mem_rd_data,
  output logic [$clog2(NROWS)-1:0]   fb_row_addr,
  input  logic [ROW_W-1:0]           fb_rd_data,
  output logic                       fb_wr_en,
  output logic [ROW_W-1:0]           fb_wr_data,
  output logic                       draw,
  output logic [$clog2(ROW_W)-1:0]   draw_x,
  output logic [$clog2(NROWS)-1:0]   draw_y,
  output logic [3:0]                 draw_row_index,
  output logic [7:0]                 sprite_data
);

  localparam int unsigned COL_W  = $clog2(ROW_W);
  localparam int unsigned ROW_AW = $clog2(NROWS);
  localparam int unsigned SUM_W  = ROW_AW + 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;

  // Latched draw context; draw_x/draw_y double as the latched start coordinates.
  logic [3:0]          n_q;
  logic [MEM_AW-1:0]   i_q;
  logic [3:0]          r_q;
  logic                acc_q;

  // Next values for every register.
  logic [COL_W-1:0]    x0_d;
  logic [ROW_AW-1:0]   y0_d;
  logic [3:0]          n_d;
  logic [MEM_AW-1:0]   i_d;
  logic [3:0]          r_d;
  logic                acc_d;
  logic                busy_d;
  logic                done_d;
  logic                collision_d;
  logic [MEM_AW-1:0]   mem_addr_d;
  logic [ROW_AW-1:0]   fb_row_addr_d;
  logic                fb_wr_en_d;
  logic [3:0]          row_index_d;

  // Datapath helpers.
  logic [ROW_W-1:0]    byte_ext;
  logic [ROW_W-1:0]    mask;
  logic [ROW_AW-1:0]   row_idx;
  logic                row_ok;
  logic                hit;
  logic                last_row;

  assign last_row = ((r_q + 4'd1) == n_q);
  assign byte_ext = {mem_rd_data, {(ROW_W-8){1'b0}}};

`ifdef CHIP8_DRAW_WRAP_EN
  logic [COL_W:0]      rot_amt;

  // Rotate the sprite byte so pixels past the right edge reappear at column 0.
  always_comb begin
    rot_amt = (COL_W+1)'(ROW_W) - (COL_W+1)'(draw_x);
    mask    = (byte_ext >> draw_x) | (byte_ext << rot_amt);
  end

  // Target row wraps modulo NROWS; every row is written.
  always_comb begin
    row_idx = draw_y + ROW_AW'(r_q);
    row_ok  = 1'b1;
  end
`else
  logic [SUM_W-1:0]    row_sum;

  // Shift the sprite byte right; pixels past the right edge fall off.
  always_comb begin
    mask = byte_ext >> draw_x;
  end

  // Rows at or below the bottom edge are skipped but still take their slot.
  always_comb begin
    row_sum = SUM_W'(draw_y) + SUM_W'(r_q);
    row_idx = row_sum[ROW_AW-1:0];
    row_ok  = (row_sum < SUM_W'(NROWS));
  end
`endif

  assign hit         = |(fb_rd_data & mask);
  assign fb_wr_data  = fb_wr_en ? (fb_rd_data ^ mask) : '0;
  assign sprite_data = fb_wr_en ? mem_rd_data : 8'd0;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (n_in == 4'd0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: state_d = S_WRITE;
      S_WRITE: state_d = last_row ? S_DONE : S_FETCH;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values; all of these are registered below.
  always_comb begin
    x0_d          = draw_x;
    y0_d          = draw_y;
    n_d           = n_q;
    i_d           = i_q;
    r_d           = r_q;
    acc_d         = acc_q;
    collision_d   = collision;
    mem_addr_d    = mem_addr;
    fb_row_addr_d = fb_row_addr;
    fb_wr_en_d    = 1'b0;
    row_index_d   = draw_row_index;
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_q == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x0_d        = COL_W'(x_in % ROW_W);
          y0_d        = ROW_AW'(y_in % NROWS);
          n_d         = n_in;
          i_d         = i_in;
          r_d         = 4'd0;
          acc_d       = 1'b0;
          collision_d = 1'b0;
          mem_addr_d  = i_in;
        end
      end
      S_FETCH: begin
        fb_wr_en_d  = row_ok;
        row_index_d = r_q;
        if (row_ok) begin
          fb_row_addr_d = row_idx;
        end
      end
      S_WRITE: begin
        if (fb_wr_en) begin
          acc_d = acc_q | hit;
        end
        r_d        = r_q + 4'd1;
        mem_addr_d = i_q + MEM_AW'(r_q) + MEM_AW'(1);
      end
      S_DONE: begin
        collision_d = acc_q;
      end
      default: begin
      end
    endcase
  end

  // Registered outputs and draw context.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      draw_x         <= '0;
      draw_y         <= '0;
      n_q            <= 4'd0;
      i_q            <= '0;
      r_q            <= 4'd0;
      acc_q          <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      collision      <= 1'b0;
      mem_addr       <= '0;
      fb_row_addr    <= '0;
      fb_wr_en       <= 1'b0;
      draw           <= 1'b0;
      draw_row_index <= 4'd0;
    end else begin
      draw_x         <= x0_d;
      draw_y         <= y0_d;
      n_q            <= n_d;
      i_q            <= i_d;
      r_q            <= r_d;
      acc_q          <= acc_d;
      busy           <= busy_d;
      done           <= done_d;
      collision      <= collision_d;
      mem_addr       <= mem_addr_d;
      fb_row_addr    <= fb_row_addr_d;
      fb_wr_en       <= fb_wr_en_d;
      draw           <= fb_wr_en_d;
      draw_row_index <= row_index_d;
    end
  end

endmodule
